// File: rtl/cordic_phase_detector.sv
// cordic_phase_detector: iterative vectoring-mode CORDIC that returns the phase and uncompensated magnitude of an I/Q sample
module cordic_phase_detector #(
  parameter int ITER = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               start_i,
  input  logic signed [15:0] x_i,
  input  logic signed [15:0] y_i,
  output logic               busy_o,
  output logic               valid_o,
  output logic        [15:0] phase_o,
  output logic        [16:0] mag_o
);
  typedef enum logic [1:0] {IDLE, ROTATE, DONE} state_t;
  localparam logic [3:0] LAST = 4'(ITER - 1);
  localparam logic [15:0] ATAN [16] = '{16'd8192, 16'd4836, 16'd2555, 16'd1297,
                                        16'd651, 16'd326, 16'd163, 16'd81,
                                        16'd41, 16'd20, 16'd10, 16'd5,
                                        16'd3, 16'd1, 16'd1, 16'd0};
  state_t             r_state, w_next;
  logic signed [17:0] r_x, r_y;
  logic        [15:0] r_z;
  logic        [3:0]  r_i;
  logic               r_zero;
  logic signed [17:0] w_xe, w_ye, w_xs, w_ys;
  assign w_xe = {{2{x_i[15]}}, x_i};
  assign w_ye = {{2{y_i[15]}}, y_i};
  assign w_xs = r_x >>> r_i;
  assign w_ys = r_y >>> r_i;
  assign busy_o = r_state != IDLE;
  always_comb begin
    w_next = r_state;
    w_next = (r_state == IDLE)   ? (start_i ? ROTATE : IDLE) :
             (r_state == ROTATE) ? ((tick && r_i == LAST) ? DONE : ROTATE) : IDLE;
  end
  always_ff @(posedge clk) r_state <= rst ? IDLE : w_next;
  // Left-half-plane inputs are pre-rotated by pi so the micro-rotations only need to cover +-pi/2.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
      r_i     <= '0;
      r_zero  <= 1'b0;
      valid_o <= 1'b0;
      phase_o <= '0;
      mag_o   <= '0;
    end else begin
      valid_o <= r_state == DONE;
      case (r_state)
        IDLE: if (start_i) begin
          r_x    <= x_i[15] ? -w_xe : w_xe;
          r_y    <= x_i[15] ? -w_ye : w_ye;
          r_z    <= x_i[15] ? 16'd32768 : 16'd0;
          r_i    <= '0;
          r_zero <= (x_i == 16'sd0) && (y_i == 16'sd0);
        end
        ROTATE: if (tick) begin
          r_x <= r_y[17] ? r_x - w_ys : r_x + w_ys;
          r_y <= r_y[17] ? r_y + w_xs : r_y - w_xs;
          r_z <= r_y[17] ? r_z - ATAN[r_i] : r_z + ATAN[r_i];
          r_i <= r_i + 4'd1;
        end
        default: begin
          phase_o <= r_zero ? 16'd0 : r_z;
          mag_o   <= r_zero ? 17'd0 : r_x[16:0];
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cordic_phase_detector.sv
// tb_cordic_phase_detector: directed checks of reset, latency, quadrant phases, magnitude and busy handling
module tb_cordic_phase_detector;
  logic clk = 1'b0, rst = 1'b1, tick = 1'b0, start_i = 1'b0;
  logic signed [15:0] x_i = '0, y_i = '0;
  logic busy_o, valid_o;
  logic [15:0] phase_o;
  logic [16:0] mag_o;
  int n_tests = 0, n_fail = 0;
  cordic_phase_detector #(.ITER(16)) dut (
    .clk(clk), .rst(rst), .tick(tick), .start_i(start_i), .x_i(x_i), .y_i(y_i),
    .busy_o(busy_o), .valid_o(valid_o), .phase_o(phase_o), .mag_o(mag_o)
  );
  always #5 clk = ~clk;
  task automatic check_eq(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic check_phase(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    logic signed [15:0] d;
    d = obs - exp;
    n_tests++;
    assert ((d >= -16'sd4 && d <= 16'sd4) === 1'b1) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d+-4", tag, obs, exp);
    end
  endtask
  task automatic check_mag(input string tag, input int obs, input int exp);
    n_tests++;
    assert ((obs >= exp - 4 && obs <= exp + 4) === 1'b1) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d+-4", tag, obs, exp);
    end
  endtask
  // mode 0: tick tied high; mode 1: tick every 4th cycle with a re-pulsed start at cycle 10
  task automatic wait_valid(input int mode, input int bound, output int lat);
    lat = -1;
    for (int n = 1; n <= bound; n++) begin
      @(negedge clk);
      tick = (mode == 0) ? 1'b1 : (n % 4 == 0);
      start_i = (mode == 1 && n == 10);
      if (mode == 1 && n == 10) begin
        x_i = -16'sd16384;
        y_i = 16'sd0;
      end
      @(posedge clk);
      #1;
      if (valid_o) begin
        lat = n;
        break;
      end
    end
    start_i = 1'b0;
  endtask
  task automatic accept(input logic signed [15:0] x, input logic signed [15:0] y);
    @(negedge clk);
    x_i = x;
    y_i = y;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    x_i = 16'sd12345;
    y_i = -16'sd321;
  endtask
  task automatic conv(input string tag, input logic signed [15:0] x, input logic signed [15:0] y,
                      input logic [15:0] ep, input int em);
    int lat;
    accept(x, y);
    wait_valid(0, 40, lat);
    check_eq({tag, "_latency"}, lat, 17);
    check_eq({tag, "_busy_in_valid"}, int'(busy_o), 0);
    check_phase({tag, "_phase"}, phase_o, ep);
    check_mag({tag, "_mag"}, int'(mag_o), em);
  endtask
  initial begin
    int lat, seen;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", int'(busy_o), 0);
    check_eq("rst_valid", int'(valid_o), 0);
    check_eq("rst_phase", int'(phase_o), 0);
    check_eq("rst_mag", int'(mag_o), 0);
    @(negedge clk);
    rst = 1'b0;
    conv("pos_x", 16'sd16384, 16'sd0, 16'd0, 26981);
    conv("pos_y", 16'sd0, 16'sd16384, 16'd16384, 26981);
    conv("neg_x", -16'sd16384, 16'sd0, 16'd32768, 26981);
    conv("neg_y", 16'sd0, -16'sd16384, 16'd49152, 26981);
    conv("corner_nn", -16'sd32768, -16'sd32768, 16'd40960, 76313);
    conv("corner_pn", 16'sd32767, -16'sd32768, 16'd57344, 76312);
    accept(16'sd0, 16'sd16384);
    tick = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("midrst_busy", int'(busy_o), 0);
    check_eq("midrst_valid", int'(valid_o), 0);
    check_eq("midrst_phase", int'(phase_o), 0);
    check_eq("midrst_mag", int'(mag_o), 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (valid_o) seen++;
    end
    check_eq("midrst_no_valid", seen, 0);
    conv("zero", 16'sd0, 16'sd0, 16'd0, 0);
    check_eq("zero_phase_exact", int'(phase_o), 0);
    check_eq("zero_mag_exact", int'(mag_o), 0);
    accept(16'sd0, 16'sd16384);
    wait_valid(1, 200, lat);
    check_eq("slow_latency", lat, 65);
    check_phase("slow_phase", phase_o, 16'd16384);
    check_mag("slow_mag", int'(mag_o), 26981);
    tick = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (valid_o) seen++;
    end
    check_eq("slow_no_second", seen, 0);
    check_eq("slow_idle", int'(busy_o), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
